// File: rtl/rv_pkg.sv
// Shared definitions for the rv core: data width, peripheral address map,
// and the data bus controller state type.
package rv_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [XLEN-1:0] ADDRESS_RAM  = 32'h0000_0000;
   localparam logic [XLEN-1:0] ADDRESS_KEY  = 32'h1000_0000;
   localparam logic [XLEN-1:0] ADDRESS_LED  = 32'h1000_0004;
   localparam logic [XLEN-1:0] ADDRESS_UART = 32'h1000_0010;

   localparam int unsigned BUS_N_SLAVES = 4;

   // Entry 0 is the rightmost element: RAM, KEY, LED, UART.
   localparam logic [BUS_N_SLAVES-1:0][XLEN-1:0] BUS_SLV_BASE = {
      ADDRESS_UART, ADDRESS_LED, ADDRESS_KEY, ADDRESS_RAM
   };
   localparam logic [BUS_N_SLAVES-1:0][XLEN-1:0] BUS_SLV_MASK = {
      32'hFFFF_FFF0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'hFFFF_0000
   };

   typedef enum logic [1:0] {
      BUS_IDLE,
      BUS_WAIT,
      BUS_ERR
   } bus_state_t;

endpackage

// File: rtl/rv_bus_addr_decoder.sv
// Combinational base/mask address decoder; the lowest-indexed matching slave
// wins when several entries overlap.
module rv_bus_addr_decoder
   import rv_pkg::*;
#(
   parameter int unsigned N_SLAVES = BUS_N_SLAVES,
   parameter int unsigned IDX_W    = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1,
   parameter logic [N_SLAVES-1:0][XLEN-1:0] SLV_BASE = BUS_SLV_BASE,
   parameter logic [N_SLAVES-1:0][XLEN-1:0] SLV_MASK = BUS_SLV_MASK
) (
   input  logic [XLEN-1:0]  addr,
   output logic             hit,
   output logic [IDX_W-1:0] idx
);

   always_comb begin
      hit = 1'b0;
      idx = '0;
      for (int unsigned k = 0; k < N_SLAVES; k++) begin
         if (!hit && ((addr & SLV_MASK[k]) == SLV_BASE[k])) begin
            hit = 1'b1;
            idx = IDX_W'(k);
         end
      end
   end

endmodule

// File: rtl/rv_data_bus_ctrl.sv
// Single-master, N-slave data bus controller: one outstanding transaction,
// error response on unmapped addresses and on slave timeout.
module rv_data_bus_ctrl
   import rv_pkg::*;
#(
   parameter int unsigned N_SLAVES       = BUS_N_SLAVES,
   parameter int unsigned TIMEOUT_CYCLES = 16,
   parameter logic [N_SLAVES-1:0][XLEN-1:0] SLV_BASE = BUS_SLV_BASE,
   parameter logic [N_SLAVES-1:0][XLEN-1:0] SLV_MASK = BUS_SLV_MASK
) (
   input  logic                     clk_i,
   input  logic                     arstn_i,
   input  logic                     data_req_i,
   output logic                     data_gnt_o,
   input  logic                     data_we_i,
   input  logic [XLEN/8-1:0]        data_be_i,
   input  logic [XLEN-1:0]          data_addr_i,
   input  logic [XLEN-1:0]          data_wdata_i,
   output logic                     data_rvalid_o,
   output logic [XLEN-1:0]          data_rdata_o,
   output logic                     data_err_o,
   output logic [N_SLAVES-1:0]      s_req_o,
   output logic                     s_we_o,
   output logic [XLEN/8-1:0]        s_be_o,
   output logic [XLEN-1:0]          s_addr_o,
   output logic [XLEN-1:0]          s_wdata_o,
   input  logic [N_SLAVES-1:0]      s_rvalid_i,
   input  logic [N_SLAVES*XLEN-1:0] s_rdata_i
);

   localparam int unsigned IDX_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   bus_state_t state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [IDX_W-1:0] sel_q, sel_d;
   logic             rvalid_d, err_d, load;
   logic [XLEN-1:0]  rdata_d;
   logic [N_SLAVES-1:0] sreq_d;

   logic             hit;
   logic [IDX_W-1:0] idx;
   logic [N_SLAVES-1:0][XLEN-1:0] rdata_arr;

   assign rdata_arr  = s_rdata_i;
   assign data_gnt_o = (state_q == BUS_IDLE);

   rv_bus_addr_decoder #(
      .N_SLAVES (N_SLAVES),
      .IDX_W    (IDX_W),
      .SLV_BASE (SLV_BASE),
      .SLV_MASK (SLV_MASK)
   ) u_dec (
      .addr (data_addr_i),
      .hit  (hit),
      .idx  (idx)
   );

   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) state_q <= BUS_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      sel_d    = sel_q;
      rvalid_d = 1'b0;
      err_d    = 1'b0;
      rdata_d  = '0;
      sreq_d   = '0;
      load     = 1'b0;
      case (state_q)
         BUS_IDLE: begin
            if (data_req_i) begin
               load = 1'b1;
               if (hit) begin
                  sreq_d[idx] = 1'b1;
                  sel_d       = idx;
                  cnt_d       = '0;
                  state_d     = BUS_WAIT;
               end else begin
                  state_d = BUS_ERR;
               end
            end
         end
         BUS_WAIT: begin
            cnt_d = cnt_q + CNT_W'(1);
            // The ack is tested first so it beats a timeout in the same cycle.
            if (s_rvalid_i[sel_q]) begin
               rvalid_d = 1'b1;
               rdata_d  = s_we_o ? '0 : rdata_arr[sel_q];
               state_d  = BUS_IDLE;
            end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               rvalid_d = 1'b1;
               err_d    = 1'b1;
               state_d  = BUS_IDLE;
            end
         end
         BUS_ERR: begin
            rvalid_d = 1'b1;
            err_d    = 1'b1;
            state_d  = BUS_IDLE;
         end
         default: state_d = BUS_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         cnt_q         <= '0;
         sel_q         <= '0;
         data_rvalid_o <= 1'b0;
         data_err_o    <= 1'b0;
         data_rdata_o  <= '0;
         s_req_o       <= '0;
         s_we_o        <= 1'b0;
         s_be_o        <= '0;
         s_addr_o      <= '0;
         s_wdata_o     <= '0;
      end else begin
         cnt_q         <= cnt_d;
         sel_q         <= sel_d;
         data_rvalid_o <= rvalid_d;
         data_err_o    <= err_d;
         data_rdata_o  <= rdata_d;
         s_req_o       <= sreq_d;
         if (load) begin
            s_we_o    <= data_we_i;
            s_be_o    <= data_be_i;
            s_addr_o  <= data_addr_i;
            s_wdata_o <= data_wdata_i;
         end
      end
   end

endmodule

// File: tb/tb_rv_data_bus_ctrl.sv
// Self-checking bench for rv_data_bus_ctrl: directed vector table, hand-written
// corner sequences and randomized transactions against a timing model.
module tb_rv_data_bus_ctrl;

   localparam int T = 16;

   logic         clk = 1'b0;
   logic         arstn;
   logic         req, we;
   logic [3:0]   be;
   logic [31:0]  addr, wdata;
   logic         gnt, rvalid, err;
   logic [31:0]  rdata;
   logic [3:0]   s_req;
   logic         s_we;
   logic [3:0]   s_be;
   logic [31:0]  s_addr, s_wdata;
   logic [3:0]   s_rvalid;
   logic [127:0] s_rdata;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   rv_data_bus_ctrl #(.N_SLAVES(4), .TIMEOUT_CYCLES(T)) dut (
      .clk_i(clk), .arstn_i(arstn),
      .data_req_i(req), .data_gnt_o(gnt), .data_we_i(we), .data_be_i(be),
      .data_addr_i(addr), .data_wdata_i(wdata),
      .data_rvalid_o(rvalid), .data_rdata_o(rdata), .data_err_o(err),
      .s_req_o(s_req), .s_we_o(s_we), .s_be_o(s_be), .s_addr_o(s_addr),
      .s_wdata_o(s_wdata), .s_rvalid_i(s_rvalid), .s_rdata_i(s_rdata)
   );

   typedef struct {
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] srd;
      int          lat;
      logic [3:0]  esreq;
      int          ecyc;
      logic        eerr;
      logic [31:0] erd;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Address map and response timing taken directly from the bus rules.
   function automatic void model(input logic [31:0] a, input logic w, input int lat,
                                 input logic [31:0] srd, output logic [3:0] sreq,
                                 output int cyc, output logic e, output logic [31:0] rd);
      int k;
      k = -1;
      if (a < 32'h0001_0000) k = 0;
      else if (a >= 32'h1000_0000 && a < 32'h1000_0004) k = 1;
      else if (a >= 32'h1000_0004 && a < 32'h1000_0008) k = 2;
      else if (a >= 32'h1000_0010 && a < 32'h1000_0020) k = 3;
      if (k < 0) begin
         sreq = 4'b0; cyc = 2; e = 1'b1; rd = 32'h0;
      end else begin
         sreq = 4'b1 << k;
         if (lat <= T - 1) begin
            cyc = lat + 2; e = 1'b0; rd = w ? 32'h0 : srd;
         end else begin
            cyc = T + 1; e = 1'b1; rd = 32'h0;
         end
      end
   endfunction

   // Called at a sample point with the controller idle; returns at the sample
   // point of the response cycle with req low.
   task automatic run_txn(input logic w, input logic [3:0] b, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] srd, input int lat,
                          input logic [3:0] esreq, input int ecyc, input logic eerr,
                          input logic [31:0] erd, input int stray, input bit hold,
                          input bit noise);
      logic [3:0] nxt;
      chk("gnt_at_accept", {31'b0, gnt}, 32'h1);
      req = 1'b1; we = w; be = b; addr = a; wdata = wd;
      for (int k = 0; k < 4; k++) begin
         s_rdata[k*32 +: 32] = $urandom;
         if (esreq[k]) s_rdata[k*32 +: 32] = srd;
      end
      s_rvalid = noise ? 4'($urandom) : 4'b0;
      for (int c = 1; c <= ecyc; c++) begin
         step();
         if (!hold) req = 1'b0;
         chk("s_req", {28'b0, s_req}, (c == 1) ? {28'b0, esreq} : 32'h0);
         chk("rvalid", {31'b0, rvalid}, (c == ecyc) ? 32'h1 : 32'h0);
         chk("err", {31'b0, err}, (c == ecyc) ? {31'b0, eerr} : 32'h0);
         chk("rdata", rdata, (c == ecyc) ? erd : 32'h0);
         chk("gnt", {31'b0, gnt}, (c == ecyc) ? 32'h1 : 32'h0);
         if (c == 1 && esreq != 4'b0) begin
            chk("s_addr", s_addr, a);
            chk("s_we", {31'b0, s_we}, {31'b0, w});
            chk("s_be", {28'b0, s_be}, {28'b0, b});
            chk("s_wdata", s_wdata, wd);
         end
         nxt = noise ? (4'($urandom) & ~esreq) : 4'b0;
         if (noise && c == ecyc) nxt = 4'($urandom);
         if (c == 1 + lat) nxt = nxt | esreq;
         if (stray >= 0 && c == 2) nxt[stray] = 1'b1;
         s_rvalid = nxt;
      end
      req = 1'b0;
   endtask

   task automatic run_vec(input vec_t v);
      run_txn(v.we, v.be, v.addr, v.wdata, v.srd, v.lat, v.esreq, v.ecyc, v.eerr,
              v.erd, -1, 1'b0, 1'b0);
   endtask

   initial begin
      logic [3:0]  m_sreq;
      int          m_cyc;
      logic        m_err;
      logic [31:0] m_rd, ra, rsrd;
      logic        rw;
      int          rlat;

      vecs[0] = '{1'b0, 4'hF, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 1,   4'b0001, 3,  1'b0, 32'hDEAD_BEEF};
      vecs[1] = '{1'b1, 4'hF, 32'h1000_0000, 32'h1111_2222, 32'h5, 1,   4'b0010, 3,  1'b0, 32'h0};
      vecs[2] = '{1'b0, 4'hF, 32'h4000_0000, 32'h0, 32'h0,         1,   4'b0000, 2,  1'b1, 32'h0};
      vecs[3] = '{1'b0, 4'h3, 32'h1000_0018, 32'h0, 32'h0000_1234, 4,   4'b1000, 6,  1'b0, 32'h0000_1234};
      vecs[4] = '{1'b0, 4'hF, 32'h0000_FFFC, 32'h0, 32'hCAFE_0001, 15,  4'b0001, 17, 1'b0, 32'hCAFE_0001};
      vecs[5] = '{1'b0, 4'hF, 32'h0000_0040, 32'h0, 32'hCAFE_0002, 16,  4'b0001, 17, 1'b1, 32'h0};
      vecs[6] = '{1'b0, 4'hF, 32'h1000_0002, 32'h0, 32'h0000_00A5, 0,   4'b0010, 2,  1'b0, 32'h0000_00A5};
      vecs[7] = '{1'b0, 4'hF, 32'h1000_0008, 32'h0, 32'h0,         1,   4'b0000, 2,  1'b1, 32'h0};
      vecs[8] = '{1'b1, 4'h1, 32'h1000_0005, 32'hAB, 32'h77,       2,   4'b0100, 4,  1'b0, 32'h0};
      vecs[9] = '{1'b0, 4'hF, 32'h1000_0004, 32'h0, 32'h0,         100, 4'b0100, 17, 1'b1, 32'h0};

      arstn = 1'b0; req = 1'b0; we = 1'b0; be = '0; addr = '0; wdata = '0;
      s_rvalid = '0; s_rdata = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_gnt", {31'b0, gnt}, 32'h1);
      chk("rst_rvalid", {31'b0, rvalid}, 32'h0);
      chk("rst_err", {31'b0, err}, 32'h0);
      chk("rst_rdata", rdata, 32'h0);
      chk("rst_s_req", {28'b0, s_req}, 32'h0);
      chk("rst_s_addr", s_addr, 32'h0);
      @(negedge clk);
      arstn = 1'b1;
      step();

      foreach (vecs[i]) run_vec(vecs[i]);

      // Late ack after a timeout is ignored; then a normal request.
      s_rvalid = 4'b0100;
      step();
      s_rvalid = 4'b0;
      chk("late_ack_ignored", {31'b0, rvalid}, 32'h0);
      step();
      chk("late_ack_ignored2", {31'b0, rvalid}, 32'h0);
      run_vec(vecs[0]);

      // Request held through WAIT, stray ack from slave 2 while slave 1 selected,
      // then a back-to-back request accepted in the response cycle.
      run_txn(1'b0, 4'hF, 32'h1000_0001, 32'h0, 32'h0BAD_F00D, 3, 4'b0010, 5, 1'b0,
              32'h0BAD_F00D, 2, 1'b1, 1'b0);
      run_vec(vecs[3]);

      // Reset in the middle of WAIT.
      chk("gnt_pre_reset", {31'b0, gnt}, 32'h1);
      req = 1'b1; we = 1'b0; be = 4'hF; addr = 32'h1000_0004;
      step();
      req = 1'b0;
      chk("reset_seq_s_req", {28'b0, s_req}, 32'h4);
      step();
      step();
      arstn = 1'b0;
      #2;
      chk("midrst_gnt", {31'b0, gnt}, 32'h1);
      chk("midrst_rvalid", {31'b0, rvalid}, 32'h0);
      chk("midrst_s_req", {28'b0, s_req}, 32'h0);
      chk("midrst_s_addr", s_addr, 32'h0);
      @(negedge clk);
      arstn = 1'b1;
      step();
      s_rvalid = 4'b0100;
      step();
      s_rvalid = 4'b0;
      chk("post_rst_ack_ignored", {31'b0, rvalid}, 32'h0);
      chk("post_rst_gnt", {31'b0, gnt}, 32'h1);
      step();
      chk("post_rst_ack_ignored2", {31'b0, rvalid}, 32'h0);

      // Randomized transactions with background noise on unrelated slave acks.
      for (int n = 0; n < 60; n++) begin
         case ($urandom_range(0, 4))
            0: ra = {16'h0, 16'($urandom)};
            1: ra = 32'h1000_0000 + 32'($urandom_range(0, 3));
            2: ra = 32'h1000_0004 + 32'($urandom_range(0, 3));
            3: ra = 32'h1000_0010 + 32'($urandom_range(0, 15));
            default: ra = 32'h2000_0000 | {4'h0, 28'($urandom)};
         endcase
         rw   = 1'($urandom);
         rlat = $urandom_range(0, 20);
         rsrd = $urandom;
         model(ra, rw, rlat, rsrd, m_sreq, m_cyc, m_err, m_rd);
         run_txn(rw, 4'($urandom), ra, $urandom, rsrd, rlat, m_sreq, m_cyc, m_err,
                 m_rd, -1, 1'($urandom), 1'b1);
         if ($urandom_range(0, 2) == 0) begin
            s_rvalid = 4'($urandom);
            step();
            chk("idle_rvalid", {31'b0, rvalid}, 32'h0);
            chk("idle_s_req", {28'b0, s_req}, 32'h0);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
